// File: rtl/accellant_uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divisor helper and frame constants.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package accellant_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } uart_tx_state_t;

  // Rounded clk cycles per bit.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with registered read data (valid the cycle after pop).
// Overflow and underflow are impossible: push is ignored when full, pop when empty.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// Stream-fed UART transmitter: valid/ready byte input, FIFO buffer, 8N1 serial output.
// Define UART_TX_PARITY_EN to add an even parity bit (8E1 frames).
module uart_tx_stream #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [7:0]                        in_data,
  output logic                              in_ready,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  import accellant_uart_pkg::*;

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_stream: CLK_FREQ_HZ/BAUD gives fewer than 2 cycles per bit");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_stream: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_tx_state_t state;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift_reg;
  logic           ready_en;
  logic           push;
  logic           pop;
  logic           baud_end;
  logic           fifo_full;
  logic           fifo_empty;
  logic [7:0]     fifo_rd_data;
`ifdef UART_TX_PARITY_EN
  logic           parity_bit;
`endif

  // Holds in_ready low through reset and releases it on the first edge after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  assign in_ready = ready_en && !fifo_full;
  assign push     = in_valid && in_ready;
  assign baud_end = (baud_cnt == CW'(DIV - 1));
  assign busy     = !fifo_empty || (state != IDLE);

  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !fifo_empty;
      STOP:    pop = baud_end && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // tx follows the state one cycle late; the popped byte lands in shift_reg on
  // the first START cycle, when the FIFO's registered read data is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      tx         <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_reg[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  tx <= parity_bit;
`endif
        default: tx <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == '0) begin
            shift_reg  <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^fifo_rd_data;
`endif
          end
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= fifo_empty ? IDLE : START;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream at DIV=4 with a mid-bit sampling receiver model.
module tb_uart_tx_stream;

  localparam int DIV   = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  rx_q[$];
  int          rx_start_q[$];
  int          rx_frame_err = 0;
  logic [10:0] rx_bits = '0;
  logic [10:0] last_bits = '0;
  int          rx_cnt = 0;
  bit          rx_active = 0;
  int          level_max = 0;
  int          ready_err = 0;
  bit          ready_chk_en = 0;
  bit          saw_not_ready = 0;

  uart_tx_stream #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD        (250_000),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: detect start, sample every bit at its middle.
  always @(negedge clk) begin
    if (!rst) begin
      rx_active = 0;
    end else begin
      if (int'(fifo_level) > level_max) level_max = int'(fifo_level);
      if (!in_ready) saw_not_ready = 1;
      if (ready_chk_en && (in_ready !== (fifo_level != 4'(DEPTH)))) ready_err++;
      if (rx_active) begin
        rx_cnt++;
        if (rx_cnt % DIV == DIV / 2) begin
          rx_bits[rx_cnt / DIV] = tx;
          if (rx_cnt / DIV == NBITS - 1) begin
            rx_active = 0;
            last_bits = rx_bits;
            rx_q.push_back(rx_bits[8:1]);
            if (rx_bits[0] !== 1'b0 || rx_bits[NBITS-1] !== 1'b1) rx_frame_err++;
`ifdef UART_TX_PARITY_EN
            if (rx_bits[9] !== ^rx_bits[8:1]) rx_frame_err++;
`endif
          end
        end
      end else if (tx === 1'b0) begin
        rx_active = 1;
        rx_cnt = 0;
        rx_start_q.push_back(cyc);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Offers a byte and returns just after the edge that accepted it; in_valid stays high.
  task automatic applyStimulus(input logic [7:0] d);
    int k = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && k < 2000) begin
      tick();
      k++;
    end
    if (!in_ready) checkOutput("push_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic waitRx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (rx_q.size() < n) checkOutput("rx_timeout", rx_q.size(), n);
  endtask

  task automatic waitIdle(output int t);
    int k = 0;
    while (busy && k < 1000) begin
      tick();
      k++;
    end
    if (busy) checkOutput("idle_timeout", 32'd1, 32'd0);
    t = cyc;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [9:0]  exp_a5_n;
    logic [10:0] exp_a5_p;
    logic [7:0]  ov[12];
    int t0, t1, base;

    exp_a5_n = 10'b11_0100_1010;
    exp_a5_p = 11'b101_0100_1010;
    ov = '{8'h3A, 8'hC1, 8'h7E, 8'h00, 8'hFF, 8'h12,
           8'h99, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h66};

    // Reset held with in_valid asserted.
    in_valid = 1'b1;
    in_data  = 8'h11;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("rst_tx", tx, 1);
      checkOutput("rst_ready", in_ready, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_level", fifo_level, 0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
    checkOutput("ready_before_edge", in_ready, 0);
    tick();
    checkOutput("ready_after_edge", in_ready, 1);
    ready_chk_en = 1;

    // Single byte 0xA5.
    applyStimulus(8'hA5);
    in_valid = 1'b0;
    t0 = cyc;
    checkOutput("a5_level_after_push", fifo_level, 1);
    checkOutput("a5_busy", busy, 1);
    checkOutput("a5_tx_idle", tx, 1);
    tick();
    checkOutput("a5_level_after_pop", fifo_level, 0);
    checkOutput("a5_tx_still_high", tx, 1);
    waitRx(1, 100);
    checkOutput("a5_byte", rx_q[0], 8'hA5);
    checkOutput("a5_start_delay", rx_start_q[0] - t0, 2);
    for (int i = 0; i < NBITS; i++) begin
`ifdef UART_TX_PARITY_EN
      checkOutput($sformatf("a5_bit%0d", i), last_bits[i], exp_a5_p[i]);
`else
      checkOutput($sformatf("a5_bit%0d", i), last_bits[i], exp_a5_n[i]);
`endif
    end
    waitIdle(t1);
    checkOutput("a5_busy_fall", t1 - t0, DIV * NBITS + 1);
    checkOutput("a5_tx_after", tx, 1);

    // Burst of three back-to-back frames.
    level_max = 0;
    base = rx_q.size();
    applyStimulus(8'h00);
    t0 = cyc;
    applyStimulus(8'hFF);
    applyStimulus(8'h55);
    in_valid = 1'b0;
    waitRx(base + 3, 300);
    checkOutput("burst_b0", rx_q[base], 8'h00);
    checkOutput("burst_b1", rx_q[base+1], 8'hFF);
    checkOutput("burst_b2", rx_q[base+2], 8'h55);
    checkOutput("burst_first_start", rx_start_q[base] - t0, 2);
    checkOutput("burst_gap01", rx_start_q[base+1] - rx_start_q[base], DIV * NBITS);
    checkOutput("burst_gap12", rx_start_q[base+2] - rx_start_q[base+1], DIV * NBITS);
    checkOutput("burst_level_peak", level_max, 2);
    waitIdle(t1);
    checkOutput("burst_busy_fall", t1 - t0, 3 * DIV * NBITS + 1);

    // Overflow: 12 bytes held against a full FIFO.
    level_max = 0;
    saw_not_ready = 0;
    base = rx_q.size();
    for (int i = 0; i < 12; i++) applyStimulus(ov[i]);
    in_valid = 1'b0;
    waitRx(base + 12, 12 * DIV * NBITS + 200);
    waitIdle(t1);
    checkOutput("ovf_count", rx_q.size() - base, 12);
    for (int i = 0; i < 12; i++)
      checkOutput($sformatf("ovf_byte%0d", i), rx_q[base+i], ov[i]);
    checkOutput("ovf_level_peak", level_max, DEPTH);
    checkOutput("ovf_saw_not_ready", saw_not_ready, 1);
    checkOutput("ready_vs_full", ready_err, 0);

    // Reset in the middle of DATA bit 3 of 0x3C, with another byte queued.
    base = rx_q.size();
    applyStimulus(8'h3C);
    t0 = cyc;
    applyStimulus(8'h5A);
    in_valid = 1'b0;
    while (cyc < t0 + 19) tick();
    checkOutput("mid_bit3", tx, 1);
    checkOutput("mid_level", fifo_level, 1);
    ready_chk_en = 0;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_tx", tx, 1);
    checkOutput("mid_rst_level", fifo_level, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_ready", in_ready, 0);
    tick();
    tick();
    checkOutput("mid_rst_tx_held", tx, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
    tick();
    checkOutput("mid_ready_back", in_ready, 1);
    ready_chk_en = 1;
    applyStimulus(8'h81);
    in_valid = 1'b0;
    waitRx(base + 1, 100);
    waitIdle(t1);
    checkOutput("post_rst_count", rx_q.size() - base, 1);
    checkOutput("post_rst_byte", rx_q[base], 8'h81);

`ifdef UART_TX_PARITY_EN
    // Even parity frames.
    base = rx_q.size();
    applyStimulus(8'h07);
    in_valid = 1'b0;
    t0 = cyc;
    waitRx(base + 1, 100);
    checkOutput("par07_byte", rx_q[base], 8'h07);
    checkOutput("par07_bit", last_bits[9], 1);
    waitIdle(t1);
    checkOutput("par07_len", t1 - t0, 45);
    applyStimulus(8'h03);
    in_valid = 1'b0;
    waitRx(base + 2, 100);
    checkOutput("par03_byte", rx_q[base+1], 8'h03);
    checkOutput("par03_bit", last_bits[9], 0);
    waitIdle(t1);
`endif

    checkOutput("frame_errors", rx_frame_err, 0);
    checkOutput("ready_vs_full_end", ready_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
